// File: rtl/rib_pkg.sv
// Shared RIB bus constants and DMA state encoding.
package rib_pkg;

  localparam int unsigned RIB_ADDR_W      = 32;
  localparam int unsigned RIB_DATA_W      = 32;
  localparam int unsigned RIB_MASK_W      = 4;
  localparam int unsigned RIB_ADDR_STRIDE = 4;

  localparam logic                  RIB_WR       = 1'b1;
  localparam logic                  RIB_RD       = 1'b0;
  localparam logic [RIB_MASK_W-1:0] RIB_MASK_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_RSP = 3'd2,
    WR_REQ = 3'd3,
    WR_RSP = 3'd4,
    DONE   = 3'd5
  } rib_dma_state_e;

  // Force a byte address onto its containing word.
  function automatic logic [RIB_ADDR_W-1:0] rib_word_align(input logic [RIB_ADDR_W-1:0] a);
    return {a[RIB_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rib_dma_master.sv
// Single-channel word-copy DMA engine, initiator side of the RIB bus.
// Each word is a RIB read from the source followed by a RIB write to the
// destination; one transaction outstanding at a time.
// Optional macro RIB_DMA_TIMEOUT_EN bounds every grant/response wait to
// TIMEOUT_CYC cycles and reports expiry on a sticky o_err.
module rib_dma_master
  import rib_pkg::*;
#(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [RIB_ADDR_W-1:0] i_src,
  input  logic [RIB_ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]      i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [RIB_ADDR_W-1:0] o_ribm_addr,
  output logic                  o_ribm_wrcs,
  output logic [RIB_MASK_W-1:0] o_ribm_mask,
  output logic [RIB_DATA_W-1:0] o_ribm_wdata,
  input  logic [RIB_DATA_W-1:0] i_ribm_rdata,
  output logic                  o_ribm_req,
  input  logic                  i_ribm_gnt,
  input  logic                  i_ribm_rsp,
  output logic                  o_ribm_rdy
);

  rib_dma_state_e        state_q, state_d;
  logic [RIB_ADDR_W-1:0] src_q, src_d;
  logic [RIB_ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [RIB_DATA_W-1:0] data_q, data_d;
  logic [RIB_ADDR_W-1:0] addr_q, addr_d;
  logic                  wrcs_q, wrcs_d;
  logic [RIB_MASK_W-1:0] mask_q, mask_d;
  logic                  req_q, req_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef RIB_DMA_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wrcs_d  = wrcs_q;
    mask_d  = RIB_MASK_ALL;
`ifdef RIB_DMA_TIMEOUT_EN
    wait_d  = '0;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          src_d   = rib_word_align(i_src);
          dst_d   = rib_word_align(i_dst);
          rem_d   = i_len;
`ifdef RIB_DMA_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (i_len == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (req_q && i_ribm_gnt) state_d = RD_RSP;
      end
      RD_RSP: begin
        if (rdy_q && i_ribm_rsp) begin
          data_d  = i_ribm_rdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (req_q && i_ribm_gnt) state_d = WR_RSP;
      end
      WR_RSP: begin
        if (rdy_q && i_ribm_rsp) begin
          src_d   = src_q + RIB_ADDR_W'(RIB_ADDR_STRIDE);
          dst_d   = dst_q + RIB_ADDR_W'(RIB_ADDR_STRIDE);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? DONE : RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef RIB_DMA_TIMEOUT_EN
    // A stalled handshake state that reaches the limit abandons the transfer.
    if ((state_q inside {RD_REQ, RD_RSP, WR_REQ, WR_RSP}) && (state_d == state_q)) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
`endif

    // Request fields load once on entry and stay frozen until the grant.
    if ((state_d == RD_REQ) && (state_q != RD_REQ)) begin
      addr_d = src_d;
      wrcs_d = RIB_RD;
    end else if ((state_d == WR_REQ) && (state_q != WR_REQ)) begin
      addr_d = dst_d;
      wrcs_d = RIB_WR;
    end

    req_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
    rdy_d  = (state_d == RD_RSP) || (state_d == WR_RSP);
    busy_d = state_d inside {RD_REQ, RD_RSP, WR_REQ, WR_RSP};
    done_d = (state_d == DONE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wrcs_q  <= 1'b0;
      mask_q  <= '0;
      req_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wrcs_q  <= wrcs_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RIB_DMA_TIMEOUT_EN
  // Wait counter and sticky error flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_ribm_addr  = addr_q;
  assign o_ribm_wrcs  = wrcs_q;
  assign o_ribm_mask  = mask_q;
  assign o_ribm_wdata = data_q;
  assign o_ribm_req   = req_q;
  assign o_ribm_rdy   = rdy_q;

endmodule

// File: tb/tb_rib_dma_master.sv
// Bench for rib_dma_master: a RIB memory responder with optional random
// backpressure, and a word-level copy model that predicts the exact
// sequence of bus transactions and data for every transfer.
module tb_rib_dma_master;

  localparam int unsigned LEN_W = 6;

  logic             clk;
  logic             rstn;
  logic             start;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             busy, done, err;
  logic [31:0]      addr, wdata, rdata;
  logic             wrcs, req, gnt, rsp, rdy;
  logic [3:0]       mask;

  rib_dma_master #(.LEN_W(LEN_W), .TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start),
    .i_src(src), .i_dst(dst), .i_len(len),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_ribm_addr(addr), .o_ribm_wrcs(wrcs), .o_ribm_mask(mask),
    .o_ribm_wdata(wdata), .i_ribm_rdata(rdata),
    .o_ribm_req(req), .i_ribm_gnt(gnt), .i_ribm_rsp(rsp), .o_ribm_rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Environment controls (written only by the test sequence).
  bit bp = 0, no_rsp = 0, stall_wr = 0, flush = 0;

  // Responder state and observed transaction log {wr, addr, data}.
  logic [64:0] log_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          stab_viol = 0;
  bit          pend = 0, armed = 0, hold_v = 0, pend_wr = 0;
  int          gdly = 0, rdly = 0;
  logic [31:0] pend_addr = '0;
  logic [68:0] hold = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory responder and request-stability monitor, acting on the falling edge.
  always @(negedge clk) begin
    if (!rstn || flush) begin
      gnt = 1'b0; rsp = 1'b0; rdata = '0;
      pend = 0; armed = 0; hold_v = 0;
      if (flush) begin
        log_q.delete();
        stab_viol = 0;
      end
    end else begin
      gnt = 1'b0;
      rsp = 1'b0;
      if (hold_v && req && ({addr, wrcs, wdata, mask} !== hold)) stab_viol++;
      if (req && mask !== 4'hF) stab_viol++;
      if (req && pend) stab_viol++;
      if (pend) begin
        if (rdly != 0) rdly--;
        else if (!no_rsp && rdy) begin
          rsp   = 1'b1;
          rdata = pend_wr ? $urandom : mem_rd(pend_addr);
          if (!pend_wr) log_q.push_back({1'b0, pend_addr, rdata});
          pend  = 0;
        end
      end else if (req) begin
        if (!armed) begin
          gdly  = bp ? $urandom_range(3, 0) : 0;
          armed = 1;
        end
        if (!(stall_wr && wrcs)) begin
          if (gdly == 0) begin
            gnt       = 1'b1;
            armed     = 0;
            pend      = 1;
            pend_addr = addr;
            pend_wr   = wrcs;
            rdly      = bp ? $urandom_range(5, 0) : 0;
            if (wrcs) begin
              mem[addr] = wdata;
              log_q.push_back({1'b1, addr, wdata});
            end
          end else begin
            gdly--;
          end
        end
      end
      hold_v = req && !gnt;
      hold   = {addr, wrcs, wdata, mask};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One complete transfer, checked against the copy model.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n,
                          input int restart_at, input bit chk_busy, input string tag);
    logic [64:0] exp_q[$];
    logic [31:0] ra, wa, v;
    int busy_n, req_n, done_n, lat, c, budget, extra_busy, nchk;
    ra = s & 32'hFFFF_FFFC;
    wa = d & 32'hFFFF_FFFC;
    for (int i = 0; i < int'(n); i++) begin
      v = ref_rd(ra);
      exp_q.push_back({1'b0, ra, v});
      exp_q.push_back({1'b1, wa, v});
      ref_mem[wa] = v;
      ra = ra + 32'd4;
      wa = wa + 32'd4;
    end
    flush = 1; tick(); flush = 0;
    start = 1'b1; src = s; dst = d; len = n;
    tick();
    start = 1'b0; src = $urandom; dst = $urandom; len = LEN_W'($urandom);
    vec_cnt++;
    if (err !== 1'b0) begin err_cnt++; $display("FAIL %s err_clear: got %b want 0", tag, err); end
    busy_n = 0; req_n = 0; done_n = 0; lat = 0; c = 1;
    budget = int'(n) * 16 + 20;
    while (done_n == 0 && c <= budget) begin
      if (busy) busy_n++;
      if (req) req_n++;
      if (done) begin
        done_n = 1;
        lat    = c;
      end else begin
        if (c == restart_at) begin
          start = 1'b1; src = s ^ 32'h0F00_0040; dst = d ^ 32'h00F0_0080; len = n ^ LEN_W'(1);
        end
        tick();
        start = 1'b0;
        c++;
      end
    end
    extra_busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_n++;
      if (busy) extra_busy++;
    end
    vec_cnt++;
    if (done_n != 1) begin err_cnt++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_n); end
    vec_cnt++;
    if (extra_busy != 0 || err !== 1'b0) begin
      err_cnt++; $display("FAIL %s idle_after: busy_cycles %0d err %b want 0 0", tag, extra_busy, err);
    end
    if (chk_busy) begin
      vec_cnt++;
      if (busy_n != 4 * int'(n)) begin err_cnt++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_n, 4 * int'(n)); end
    end
    if (n == '0) begin
      vec_cnt++;
      if (lat > 2 || req_n != 0) begin err_cnt++; $display("FAIL %s zero_len: latency %0d req_cycles %0d want <=2 0", tag, lat, req_n); end
    end
    vec_cnt++;
    if (log_q.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL %s txn_count: got %0d want %0d", tag, log_q.size(), exp_q.size());
    end
    nchk = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) begin
      vec_cnt++;
      if (log_q[i] !== exp_q[i]) begin
        err_cnt++; $display("FAIL %s txn[%0d]: got %h want %h", tag, i, log_q[i], exp_q[i]);
      end
    end
    vec_cnt++;
    if (stab_viol != 0) begin err_cnt++; $display("FAIL %s req_stability: got %0d violations want 0", tag, stab_viol); end
  endtask

  task automatic test_reset();
    logic [73:0] outs;
    rstn = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    tick(); tick();
    outs = {busy, done, err, addr, wrcs, mask, wdata, req, rdy};
    vec_cnt++;
    if (outs !== '0) begin err_cnt++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rstn = 1'b1;
    tick(); tick();
    vec_cnt++;
    if ({busy, done, req, rdy} !== 4'b0) begin err_cnt++; $display("FAIL reset_release: got %b want 0000", {busy, done, req, rdy}); end
  endtask

  task automatic test_basic();
    run_xfer(32'h0000_1000, 32'h0000_2000, LEN_W'(3), 0, 1, "basic");
  endtask

  task automatic test_zero_len();
    run_xfer(32'h0000_1234, 32'h0000_5678, '0, 0, 1, "zero_len");
  endtask

  task automatic test_start_while_busy();
    run_xfer(32'h0000_3000, 32'h0000_4000, LEN_W'(3), 5, 1, "start_busy");
  endtask

  task automatic test_backpressure();
    bp = 1;
    for (int k = 0; k < 5; k++) begin
      run_xfer(32'h0001_0000 + ($urandom & 32'h0000_FFFF), 32'h0100_0000 + ($urandom & 32'h0000_FFFF),
               LEN_W'($urandom_range(8, 1)), 0, 0, "backpressure");
    end
    bp = 0;
  endtask

  task automatic test_addr_wrap();
    run_xfer(32'hFFFF_FFFE, 32'h0000_5000, LEN_W'(2), 0, 1, "src_wrap");
    run_xfer(32'h0000_6001, 32'hFFFF_FFF9, LEN_W'(3), 0, 1, "dst_wrap");
  endtask

  task automatic test_max_len();
    run_xfer(32'h0000_6000, 32'h0000_7000, '1, 0, 1, "max_len");
  endtask

  task automatic test_reset_midflight();
    logic [73:0] outs;
    bit found;
    stall_wr = 1;
    flush = 1; tick(); flush = 0;
    start = 1'b1; src = 32'h0000_8000; dst = 32'h0000_9000; len = LEN_W'(2);
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (req && wrcs) found = 1;
      else tick();
    end
    vec_cnt++;
    if (!found) begin err_cnt++; $display("FAIL midflight_reach_wr_req: got 0 want 1"); end
    rstn = 1'b0;
    #1;
    outs = {busy, done, err, addr, wrcs, mask, wdata, req, rdy};
    vec_cnt++;
    if (outs !== '0) begin err_cnt++; $display("FAIL midflight_reset_outputs: got %h want 0", outs); end
    tick(); tick();
    stall_wr = 0;
    rstn = 1'b1;
    tick(); tick();
    vec_cnt++;
    if ({busy, done, req} !== 3'b0) begin err_cnt++; $display("FAIL midflight_idle: got %b want 000", {busy, done, req}); end
    run_xfer(32'h0000_8000, 32'h0000_9000, LEN_W'(2), 0, 1, "after_reset");
  endtask

`ifdef RIB_DMA_TIMEOUT_EN
  task automatic test_timeout();
    int rdy_n, done_n;
    logic err_at;
    no_rsp = 1;
    flush = 1; tick(); flush = 0;
    start = 1'b1; src = 32'h0000_A000; dst = 32'h0000_B000; len = LEN_W'(1);
    tick();
    start = 1'b0;
    rdy_n = 0; done_n = 0; err_at = 1'b0;
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      if (rdy) rdy_n++;
      if (done) begin done_n = 1; err_at = err; end
      else tick();
    end
    vec_cnt++;
    if (done_n != 1) begin err_cnt++; $display("FAIL timeout_done: got %0d want 1", done_n); end
    vec_cnt++;
    if (rdy_n != 8) begin err_cnt++; $display("FAIL timeout_rdy_cycles: got %0d want 8", rdy_n); end
    vec_cnt++;
    if (err_at !== 1'b1) begin err_cnt++; $display("FAIL timeout_err: got %b want 1", err_at); end
    tick(); tick();
    vec_cnt++;
    if ({err, busy, req, rdy} !== 4'b1000) begin err_cnt++; $display("FAIL timeout_sticky: got %b want 1000", {err, busy, req, rdy}); end
    vec_cnt++;
    if (log_q.size() != 0) begin err_cnt++; $display("FAIL timeout_no_write: got %0d txns want 0", log_q.size()); end
    no_rsp = 0;
    run_xfer(32'h0000_A000, 32'h0000_B000, LEN_W'(2), 0, 1, "after_timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_start_while_busy();
    test_backpressure();
    test_addr_wrap();
    test_max_len();
    test_reset_midflight();
`ifdef RIB_DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
